// File: rtl/pc_clk_pkg.sv
// pc_clk_pkg: shared types, constants and helpers for the PC clock generator.
//   pc_state_e  : FSM states (PC_IDLE parked low, PC_HIGH, PC_LOW)
//   PC_MIN_DIV  : smallest legal divisor; requests below it are clamped up
//   pc_phases() : splits a divisor into high (ceiling half) / low (floor half)
package pc_clk_pkg;

  typedef enum logic [1:0] {
    PC_IDLE = 2'd0,
    PC_HIGH = 2'd1,
    PC_LOW  = 2'd2
  } pc_state_e;

  localparam int PC_MIN_DIV = 2;

  typedef struct packed {
    logic [31:0] high_len;
    logic [31:0] low_len;
  } pc_phase_t;

  // Odd divisors put the extra cycle in the high phase (D=5 -> 3 high / 2 low).
  function automatic pc_phase_t pc_phases(input logic [31:0] div);
    pc_phase_t p;
    p.low_len  = div >> 1;
    p.high_len = div - p.low_len;
    return p;
  endfunction

endpackage

// File: rtl/pc_clk_reload.sv
// pc_clk_reload: divisor register with div_load/div_ack handshake.
//   clk_in, rst_n : clock, async active-low reset
//   div_in        : requested divisor (0/1 clamped to PC_MIN_DIV)
//   div_load      : reload request, held until div_ack
//   in_idle       : generator parked; reload may happen on the next edge
//   at_boundary   : last low cycle of a period; reload may happen here
//   div_eff       : divisor in force for any period starting at this edge
//   div_ack       : one-cycle pulse when the new divisor is latched
module pc_clk_reload
  import pc_clk_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  input  logic             in_idle,
  input  logic             at_boundary,
  output logic [CNT_W-1:0] div_eff,
  output logic             div_ack
);

  logic [CNT_W-1:0] div_q_reg;
  logic [CNT_W-1:0] div_clamped;
  logic             div_ack_reg;
  logic             take;

  assign div_clamped = (div_in < CNT_W'(PC_MIN_DIV)) ? CNT_W'(PC_MIN_DIV) : div_in;

  // The requester still holds div_load during the ack cycle, so a reload is
  // suppressed while div_ack is high to keep the ack a single pulse.
  assign take = div_load && !div_ack_reg && (in_idle || at_boundary);

  // A period that starts on the reload edge already uses the new divisor.
  assign div_eff = take ? div_clamped : div_q_reg;
  assign div_ack = div_ack_reg;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q_reg   <= CNT_W'(RESET_DIV);
      div_ack_reg <= 1'b0;
    end else begin
      div_ack_reg <= take;
      if (take) begin
        div_q_reg <= div_clamped;
      end
    end
  end

endmodule

// File: rtl/pc_clk_gen.sv
// pc_clk_gen: programmable-ratio divided clock for the PC/pipeline stage.
//   clk_in, rst_n        : clock, async active-low reset
//   en                   : run enable (periods always complete, no runts)
//   div_in/div_load/div_ack : divisor reload handshake, applied at period
//                          boundaries or immediately when parked
//   step_mode, step_req, step_done : single-step debug (needs PC_CLK_STEP_EN)
//   clk_out              : registered divided clock
//   rise_pulse/fall_pulse: first cycle of clk_out high / low
// Build option: define PC_CLK_STEP_EN to enable single-step mode; otherwise
// step inputs are ignored and step_done stays 0.
module pc_clk_gen
  import pc_clk_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  input  logic             step_mode,
  input  logic             step_req,
  output logic             step_done,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             fall_pulse
);

  pc_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             step_active_reg, step_active_next;
  logic             clk_out_reg, clk_out_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;
  logic             done_reg, done_next;

  logic             go;
  logic             step_sel;
  logic             stop_at_end;
  logic             at_boundary;
  logic [CNT_W-1:0] div_eff;
  pc_phase_t        phases;

`ifdef PC_CLK_STEP_EN
  assign step_sel = step_mode;
  assign go       = step_mode ? step_req : en;
`else
  logic unused_step;
  assign unused_step = step_mode ^ step_req;
  assign step_sel    = 1'b0;
  assign go          = en;
`endif

  assign at_boundary = (state_reg == PC_LOW) && (cnt_reg == '0);
  // A stepped period (or step mode selected now) always parks at its end.
  assign stop_at_end = step_active_reg || step_sel;

  pc_clk_reload #(
    .CNT_W     (CNT_W),
    .RESET_DIV (RESET_DIV)
  ) u_reload (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .div_in      (div_in),
    .div_load    (div_load),
    .in_idle     (state_reg == PC_IDLE),
    .at_boundary (at_boundary),
    .div_eff     (div_eff),
    .div_ack     (div_ack)
  );

  // div_eff only differs from the latched divisor in IDLE or at a boundary,
  // so it is also the right source for the low-phase length taken in HIGH.
  assign phases = pc_phases(32'(div_eff));

  // State register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= PC_IDLE;
      cnt_reg         <= '0;
      step_active_reg <= 1'b0;
      clk_out_reg     <= 1'b0;
      rise_reg        <= 1'b0;
      fall_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      step_active_reg <= step_active_next;
      clk_out_reg     <= clk_out_next;
      rise_reg        <= rise_next;
      fall_reg        <= fall_next;
      done_reg        <= done_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    step_active_next = step_active_reg;
    case (state_reg)
      PC_IDLE: begin
        if (go) begin
          state_next       = PC_HIGH;
          cnt_next         = CNT_W'(phases.high_len - 32'd1);
          step_active_next = step_sel;
        end
      end
      PC_HIGH: begin
        if (cnt_reg == '0) begin
          state_next = PC_LOW;
          cnt_next   = CNT_W'(phases.low_len - 32'd1);
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      PC_LOW: begin
        if (cnt_reg == '0) begin
          if (go && !stop_at_end) begin
            state_next = PC_HIGH;
            cnt_next   = CNT_W'(phases.high_len - 32'd1);
          end else begin
            state_next       = PC_IDLE;
            cnt_next         = '0;
            step_active_next = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next       = PC_IDLE;
        cnt_next         = '0;
        step_active_next = 1'b0;
      end
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    clk_out_next = (state_next == PC_HIGH);
    rise_next    = (state_next == PC_HIGH) && (state_reg != PC_HIGH);
    fall_next    = (state_reg == PC_HIGH) && (state_next == PC_LOW);
    done_next    = at_boundary && stop_at_end;
  end

  assign clk_out    = clk_out_reg;
  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;
  assign step_done  = done_reg;

endmodule

// File: tb/tb_pc_clk_gen.sv
// tb_pc_clk_gen: directed self-checking bench for pc_clk_gen (RESET_DIV=2).
module tb_pc_clk_gen;

  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
  logic             div_ack;
  logic             step_mode;
  logic             step_req;
  logic             step_done;
  logic             clk_out;
  logic             rise_pulse;
  logic             fall_pulse;

  int n_pass  = 0;
  int n_total = 0;

  pc_clk_gen #(
    .CNT_W     (CNT_W),
    .RESET_DIV (2)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .en         (en),
    .div_in     (div_in),
    .div_load   (div_load),
    .div_ack    (div_ack),
    .step_mode  (step_mode),
    .step_req   (step_req),
    .step_done  (step_done),
    .clk_out    (clk_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_ack(input string tag, input int limit);
    int k;
    k = 0;
    while (div_ack !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
    check(tag, 32'(div_ack), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_in = '0;
    step_mode = 1'b0; step_req = 1'b0;
    repeat (2) tick();
    check("rst_clk", 32'(clk_out), 0);
    check("rst_rise", 32'(rise_pulse), 0);
    check("rst_fall", 32'(fall_pulse), 0);
    check("rst_ack", 32'(div_ack), 0);
    check("rst_done", 32'(step_done), 0);
    rst_n = 1'b1;
    tick();
    check("idle_clk", 32'(clk_out), 0);

    // D=5 loaded while parked: ack after one edge
    div_in = 8'd5; div_load = 1'b1;
    tick();
    check("ack5_idle", 32'(div_ack), 1);
    div_load = 1'b0; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("d5_clk_%0d", i), 32'(clk_out), 32'((i % 5) < 3));
      check($sformatf("d5_rise_%0d", i), 32'(rise_pulse), 32'((i % 5) == 0));
      check($sformatf("d5_fall_%0d", i), 32'(fall_pulse), 32'((i % 5) == 3));
    end

    // At the boundary: reload to D=4 takes effect on the period starting there
    div_in = 8'd4; div_load = 1'b1;
    tick();
    check("ack4_bnd", 32'(div_ack), 1);
    check("d4_rise0", 32'(rise_pulse), 1);
    div_load = 1'b0;
    tick();
    check("d4_clk1", 32'(clk_out), 1);
    check("d4_ack1", 32'(div_ack), 0);

    // Request D=7 mid-HIGH: current period stays 2/2, ack at its boundary
    div_in = 8'd7; div_load = 1'b1;
    tick();
    check("d4_clk2", 32'(clk_out), 0);
    check("d4_fall2", 32'(fall_pulse), 1);
    check("d4_ack2", 32'(div_ack), 0);
    tick();
    check("d4_clk3", 32'(clk_out), 0);
    check("d4_ack3", 32'(div_ack), 0);
    tick();
    check("ack7_bnd", 32'(div_ack), 1);
    check("d7_rise0", 32'(rise_pulse), 1);
    div_load = 1'b0;
    for (int i = 1; i < 7; i++) begin
      tick();
      check($sformatf("d7_clk_%0d", i), 32'(clk_out), 32'(i < 4));
      check($sformatf("d7_fall_%0d", i), 32'(fall_pulse), 32'(i == 4));
    end
    tick();
    check("d7_next_rise", 32'(rise_pulse), 1);

    // D=8, drop en on its first high cycle: full 4/4 then park
    div_in = 8'd8; div_load = 1'b1;
    wait_ack("ack8", 20);
    check("d8_rise0", 32'(rise_pulse), 1);
    en = 1'b0; div_load = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("d8_clk_%0d", i), 32'(clk_out), 32'(i < 4));
      check($sformatf("d8_fall_%0d", i), 32'(fall_pulse), 32'(i == 4));
    end
    tick();
    check("d8_park_clk", 32'(clk_out), 0);
    check("d8_park_rise", 32'(rise_pulse), 0);
    tick();
    check("d8_park_clk2", 32'(clk_out), 0);
    en = 1'b1;
    tick();
    check("d8_rearm_rise", 32'(rise_pulse), 1);
    check("d8_rearm_clk", 32'(clk_out), 1);

    // Park again, then load div_in=0 (treated as 2)
    en = 1'b0;
    repeat (7) tick();
    tick();
    check("park2_clk", 32'(clk_out), 0);
    div_in = 8'd0; div_load = 1'b1;
    tick();
    check("ack0_idle", 32'(div_ack), 1);
    div_load = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("d2_clk_%0d", i), 32'(clk_out), 32'((i % 2) == 0));
      check($sformatf("d2_rise_%0d", i), 32'(rise_pulse), 32'((i % 2) == 0));
      check($sformatf("d2_fall_%0d", i), 32'(fall_pulse), 32'((i % 2) == 1));
    end

    // D=6, async reset asserted mid-HIGH
    div_in = 8'd6; div_load = 1'b1;
    wait_ack("ack6", 10);
    check("d6_rise0", 32'(rise_pulse), 1);
    div_load = 1'b0;
    tick();
    check("d6_clk1", 32'(clk_out), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_clk", 32'(clk_out), 0);
    check("arst_rise", 32'(rise_pulse), 0);
    check("arst_fall", 32'(fall_pulse), 0);
    tick();
    check("arst_clk_edge", 32'(clk_out), 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_rise", 32'(rise_pulse), 1);
    check("post_rst_clk0", 32'(clk_out), 1);
    tick();
    check("post_rst_clk1", 32'(clk_out), 0);
    check("post_rst_fall", 32'(fall_pulse), 1);
    tick();
    check("post_rst_clk2", 32'(clk_out), 1);
    check("post_rst_done", 32'(step_done), 0);

`ifdef PC_CLK_STEP_EN
    // Single-step: D=3 gives exactly 1,1,0 then step_done and park
    en = 1'b0; step_mode = 1'b1;
    repeat (3) tick();
    check("step_park_clk", 32'(clk_out), 0);
    div_in = 8'd3; div_load = 1'b1;
    tick();
    check("ack3_idle", 32'(div_ack), 1);
    div_load = 1'b0;
    step_req = 1'b1;
    tick();
    check("step_clk0", 32'(clk_out), 1);
    check("step_rise0", 32'(rise_pulse), 1);
    // second request while HIGH: ignored
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("step_clk1", 32'(clk_out), 1);
    check("step_done1", 32'(step_done), 0);
    tick();
    check("step_clk2", 32'(clk_out), 0);
    check("step_fall2", 32'(fall_pulse), 1);
    tick();
    check("step_done3", 32'(step_done), 1);
    check("step_clk3", 32'(clk_out), 0);
    tick();
    check("step_done4", 32'(step_done), 0);
    check("step_clk4", 32'(clk_out), 0);
    check("step_rise4", 32'(rise_pulse), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
